// File: rtl/wbgen_pkg.sv
// wbgen_pkg: shared types and helpers for the Wishbone traffic generator.
//   wbgen_state_e : sequencer states
//   LFSR_POLY     : Galois feedback mask (right-shifting form)
//   DEFAULT_SEED  : default LFSR seed
//   bl_eff()      : effective burst length (0 -> 1, clamp to max_bl)
//   lfsr_next()   : one LFSR step
package wbgen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitInit,
    StWrBeat,
    StWrGap,
    StRdBeat,
    StRdGap,
    StDone
  } wbgen_state_e;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2024;

  function automatic logic [7:0] bl_eff(input logic [7:0] cfg_bl, input int unsigned max_bl);
    if (cfg_bl == 8'd0) return 8'd1;
    if (32'(cfg_bl) > max_bl) return 8'(max_bl);
    return cfg_bl;
  endfunction

  // Galois step: shift right, fold the mask in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'd0);
  endfunction

endpackage

// File: rtl/wbgen_lfsr.sv
// wbgen_lfsr: 32-bit Galois LFSR holding the expected/generated data word.
//   sys_clk  : clock
//   RESETN   : asynchronous active-low reset, value returns to ResetVal
//   load     : reload from seed (a zero seed becomes 1); has priority over advance
//   seed     : reload value
//   advance  : step once
//   value    : current LFSR state
module wbgen_lfsr
  import wbgen_pkg::*;
#(
  parameter logic [31:0] ResetVal = DEFAULT_SEED
) (
  input  logic        sys_clk,
  input  logic        RESETN,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] value_q;

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      value_q <= ResetVal;
    end else if (load) begin
      value_q <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/wb_traffic_gen.sv
// wb_traffic_gen: Wishbone master that writes cfg_num_bursts bursts of LFSR data starting at
// cfg_start_addr, then reads them back in the same order and checks every beat.
//   Control : sys_clk, RESETN (async active-low), sdr_init_done, start (1-cycle pulse)
//   Config  : cfg_start_addr (word addr), cfg_bl (beats/burst), cfg_num_bursts
//   Status  : busy, done (sticky), pass, err_cnt (saturating), first_err_addr, timeout
//   Bus     : wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o, wb_dat_i, wb_ack_i
// Optional: define WBGEN_TIMEOUT_EN to abort a run when a beat waits TIMEOUT cycles for ack;
// without it timeout stays 0 and the sequencer waits for ack indefinitely.
module wb_traffic_gen
  import wbgen_pkg::*;
#(
  parameter int unsigned AW      = 30,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_BL  = 16,
  parameter logic [31:0] SEED    = DEFAULT_SEED,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  input  logic            start,
  input  logic [AW-1:0]   cfg_start_addr,
  input  logic [7:0]      cfg_bl,
  input  logic [7:0]      cfg_num_bursts,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_cnt,
  output logic [AW-1:0]   first_err_addr,
  output logic            timeout,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  localparam logic [31:0] SeedEff = (SEED == 32'd0) ? 32'd1 : SEED;

  if (MAX_BL < 1 || MAX_BL > 255 || TIMEOUT < 1) begin : g_param_check
    $error("wb_traffic_gen: MAX_BL must be 1..255 and TIMEOUT at least 1");
  end

  // Spread the 32-bit LFSR word across any data width.
  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    logic [DW-1:0] r;
    for (int unsigned i = 0; i < DW; i++) r[i] = v[i % 32];
    return r;
  endfunction

  wbgen_state_e    state_q;
  logic [7:0]      bl_q, nb_q, beat_q, burst_q;
  logic [AW-1:0]   start_q, base_q;
  logic            busy_q, done_q, pass_q, timeout_q;
  logic [15:0]     err_cnt_q;
  logic [AW-1:0]   first_err_q;
  logic            cyc_q, stb_q, we_q;
  logic [DW/8-1:0] sel_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   dat_q;

  logic        lfsr_load, lfsr_adv;
  logic [31:0] lfsr_val;
  logic        in_beat, acked, last_beat, last_burst, tmo_hit;
  logic [AW-1:0] next_base;

  assign in_beat    = stb_q && (state_q == StWrBeat || state_q == StRdBeat);
  assign acked      = in_beat && wb_ack_i;
  assign last_beat  = (beat_q == bl_q - 8'd1);
  assign last_burst = (burst_q == nb_q - 8'd1);
  assign next_base  = base_q + AW'(bl_q);

  assign lfsr_load = ((state_q == StIdle || state_q == StDone) && start) ||
                     (state_q == StWrGap && last_burst);
  assign lfsr_adv  = acked;

  wbgen_lfsr #(
    .ResetVal (SeedEff)
  ) u_lfsr (
    .sys_clk (sys_clk),
    .RESETN  (RESETN),
    .load    (lfsr_load),
    .seed    (SeedEff),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

`ifdef WBGEN_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  // Restarts on every ack and whenever no beat is pending, so each beat gets a fresh budget.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      tmo_cnt_q <= '0;
    end else if (!in_beat || wb_ack_i) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = in_beat && !wb_ack_i && (tmo_cnt_q == TmoW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= StIdle;
      bl_q        <= 8'd0;
      nb_q        <= 8'd0;
      beat_q      <= 8'd0;
      burst_q     <= 8'd0;
      start_q     <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= 16'd0;
      first_err_q <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            start_q     <= cfg_start_addr;
            base_q      <= cfg_start_addr;
            bl_q        <= bl_eff(cfg_bl, MAX_BL);
            nb_q        <= cfg_num_bursts;
            beat_q      <= 8'd0;
            burst_q     <= 8'd0;
            err_cnt_q   <= 16'd0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StWaitInit;
          end
        end

        StWaitInit: begin
          if (sdr_init_done) begin
            if (nb_q == 8'd0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= '1;
              addr_q  <= base_q;
              dat_q   <= rep(lfsr_val);
              state_q <= StWrBeat;
            end
          end
        end

        StWrBeat, StRdBeat: begin
          if (acked) begin
            if (state_q == StRdBeat && wb_dat_i != rep(lfsr_val)) begin
              if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
              if (err_cnt_q == 16'd0) first_err_q <= addr_q;
            end
            if (last_beat) begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              sel_q   <= '0;
              beat_q  <= 8'd0;
              state_q <= (state_q == StWrBeat) ? StWrGap : StRdGap;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_q + 1'b1;
              // Present the word the LFSR steps to on this same edge.
              if (state_q == StWrBeat) dat_q <= rep(lfsr_next(lfsr_val));
            end
          end else if (tmo_hit) begin
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= StDone;
          end
        end

        StWrGap: begin
          cyc_q <= 1'b1;
          stb_q <= 1'b1;
          sel_q <= '1;
          if (last_burst) begin
            // LFSR reloads on this edge, so reads start comparing against SEED.
            burst_q <= 8'd0;
            base_q  <= start_q;
            addr_q  <= start_q;
            we_q    <= 1'b0;
            state_q <= StRdBeat;
          end else begin
            burst_q <= burst_q + 8'd1;
            base_q  <= next_base;
            addr_q  <= next_base;
            dat_q   <= rep(lfsr_val);
            state_q <= StWrBeat;
          end
        end

        StRdGap: begin
          if (last_burst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_q == 16'd0) && !timeout_q;
            state_q <= StDone;
          end else begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            sel_q   <= '1;
            burst_q <= burst_q + 8'd1;
            base_q  <= next_base;
            addr_q  <= next_base;
            state_q <= StRdBeat;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign timeout        = timeout_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = stb_q;
  assign wb_we_o        = we_q;
  assign wb_addr_o      = addr_q;
  assign wb_sel_o       = sel_q;
  assign wb_dat_o       = dat_q;

endmodule

// File: tb/tb_wb_traffic_gen.sv
// tb_wb_traffic_gen: directed bench for wb_traffic_gen with a Wishbone slave model that acks
// one cycle after stb, stores writes, returns them on reads, and can corrupt or stall.
module tb_wb_traffic_gen;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic            sys_clk = 1'b0;
  logic            RESETN = 1'b0;
  logic            sdr_init_done = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   cfg_start_addr = '0;
  logic [7:0]      cfg_bl = 8'd0;
  logic [7:0]      cfg_num_bursts = 8'd0;
  logic            busy, done, pass, timeout;
  logic [15:0]     err_cnt;
  logic [AW-1:0]   first_err_addr;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;

  int n_checks = 0;
  int n_pass   = 0;

  wb_traffic_gen #(
    .AW      (AW),
    .DW      (DW),
    .MAX_BL  (16),
    .SEED    (32'h0000_0001),
    .TIMEOUT (1024)
  ) dut (
    .sys_clk        (sys_clk),
    .RESETN         (RESETN),
    .sdr_init_done  (sdr_init_done),
    .start          (start),
    .cfg_start_addr (cfg_start_addr),
    .cfg_bl         (cfg_bl),
    .cfg_num_bursts (cfg_num_bursts),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .timeout        (timeout),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_addr_o      (wb_addr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- slave model and transaction log ----------------
  bit              stall_ack = 1'b0;
  bit              corrupt_en = 1'b0;
  logic [AW-1:0]   corrupt_addr = '0;
  logic [31:0]     mem [logic [AW-1:0]];
  logic            log_we [$];
  logic [AW-1:0]   log_addr [$];
  logic [31:0]     log_dat [$];
  int              gap_runs [$];
  int              run_len = 0;
  bit              seen_hi = 1'b0;

  initial begin
    logic          prev_stb, prev_we, hs;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_dat;
    prev_stb = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_dat = '0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge sys_clk or negedge RESETN);
      if (!RESETN) begin
        wb_ack_i = 1'b0;
        prev_stb = 1'b0;
      end else begin
        #1;
        // Outputs seen now are post-edge; prev_* hold what was on the bus during the last cycle.
        hs = wb_ack_i && prev_stb;
        if (hs) begin
          log_we.push_back(prev_we);
          log_addr.push_back(prev_addr);
          log_dat.push_back(prev_we ? prev_dat : wb_dat_i);
          if (prev_we) mem[prev_addr] = prev_dat;
        end
        if (prev_stb && wb_cyc_o && wb_stb_o && !hs && !stall_ack) begin
          wb_ack_i = 1'b1;
          if (!wb_we_o) begin
            wb_dat_i = mem.exists(wb_addr_o) ? mem[wb_addr_o] : 32'd0;
            if (corrupt_en && wb_addr_o == corrupt_addr) wb_dat_i[0] = ~wb_dat_i[0];
          end
        end else begin
          wb_ack_i = 1'b0;
        end
        if (busy) begin
          if (wb_cyc_o) begin
            if (run_len > 0) gap_runs.push_back(run_len);
            run_len = 0;
            seen_hi = 1'b1;
          end else if (seen_hi) begin
            run_len++;
          end
        end else begin
          if (run_len > 0) gap_runs.push_back(run_len);
          run_len = 0;
          seen_hi = 1'b0;
        end
        prev_stb  = wb_cyc_o && wb_stb_o;
        prev_we   = wb_we_o;
        prev_addr = wb_addr_o;
        prev_dat  = wb_dat_o;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 3000000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers (stimulus only) ----------------
  function automatic logic [31:0] tb_next(input logic [31:0] v);
    logic [31:0] s;
    s = {1'b0, v[31:1]};
    if (v[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [118:0] all_outs();
    return {busy, done, pass, timeout, err_cnt, first_err_addr, wb_cyc_o, wb_stb_o, wb_we_o,
            wb_addr_o, wb_sel_o, wb_dat_o};
  endfunction

  task automatic clear_logs();
    log_we.delete();
    log_addr.delete();
    log_dat.delete();
    gap_runs.delete();
    run_len = 0;
    seen_hi = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [7:0] bl, input logic [7:0] nb);
    @(negedge sys_clk);
    cfg_start_addr = a;
    cfg_bl         = bl;
    cfg_num_bursts = nb;
    start          = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [AW-1:0] a, input logic [7:0] bl, input logic [7:0] nb,
                     output bit got);
    clear_logs();
    pulse_start(a, bl, nb);
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge sys_clk);
      if (done) got = 1'b1;
    end
    @(negedge sys_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESETN = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_outputs: got %h, required 0", all_outs());
    else n_pass++;
    n_checks++;
    if (wb_cyc_o !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_cyc_busy: got cyc=%b busy=%b, required 0/0", wb_cyc_o, busy);
    else n_pass++;
    RESETN = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_single_burst();
    bit got;
    logic [31:0] exp_wd [4];
    exp_wd = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    sdr_init_done = 1'b1;
    run(30'h1_0000, 8'd4, 8'd1, got);
    n_checks++;
    if (got !== 1'b1) $display("FAIL single_done_wait: got %b, required 1", got); else n_pass++;
    n_checks++;
    if (log_addr.size() !== 8) $display("FAIL single_beats: got %0d, required 8", log_addr.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (log_we[i] !== 1'b1 || log_addr[i] !== 30'h1_0000 + AW'(i) || log_dat[i] !== exp_wd[i])
        $display("FAIL single_write%0d: got we=%b addr=%h dat=%h, required 1/%h/%h", i,
                 log_we[i], log_addr[i], log_dat[i], 30'h1_0000 + AW'(i), exp_wd[i]);
      else n_pass++;
      n_checks++;
      if (log_we[4+i] !== 1'b0 || log_addr[4+i] !== 30'h1_0000 + AW'(i) ||
          log_dat[4+i] !== exp_wd[i])
        $display("FAIL single_read%0d: got we=%b addr=%h dat=%h, required 0/%h/%h", i,
                 log_we[4+i], log_addr[4+i], log_dat[4+i], 30'h1_0000 + AW'(i), exp_wd[i]);
      else n_pass++;
    end
    n_checks++;
    if (gap_runs.size() !== 2 || gap_runs[0] !== 1 || gap_runs[1] !== 1)
      $display("FAIL single_gaps: got count=%0d first=%0d, required 2 gaps of 1",
               gap_runs.size(), gap_runs[0]);
    else n_pass++;
    n_checks++;
    if ({done, pass, busy, timeout, err_cnt} !== {4'b1100, 16'd0})
      $display("FAIL single_status: got done=%b pass=%b busy=%b tmo=%b err=%0d, required 1/1/0/0/0",
               done, pass, busy, timeout, err_cnt);
    else n_pass++;
  endtask

  task automatic test_corrupt();
    bit got;
    corrupt_en   = 1'b1;
    corrupt_addr = 30'h1_0002;
    run(30'h1_0000, 8'd4, 8'd1, got);
    corrupt_en = 1'b0;
    n_checks++;
    if (got !== 1'b1 || done !== 1'b1)
      $display("FAIL corrupt_done: got %b/%b, required 1/1", got, done);
    else n_pass++;
    n_checks++;
    if (err_cnt !== 16'd1) $display("FAIL corrupt_err_cnt: got %0d, required 1", err_cnt);
    else n_pass++;
    n_checks++;
    if (first_err_addr !== 30'h1_0002)
      $display("FAIL corrupt_first_addr: got %h, required 00010002", first_err_addr);
    else n_pass++;
    n_checks++;
    if (pass !== 1'b0) $display("FAIL corrupt_pass: got %b, required 0", pass); else n_pass++;
  endtask

  task automatic test_clamp_gap();
    bit got;
    int nwr, bad, gmin, gmax;
    logic [31:0] v;
    // cfg_bl=0 behaves as one beat per burst.
    run(30'h200, 8'd0, 8'd2, got);
    n_checks++;
    if (got !== 1'b1 || log_addr.size() !== 4 || log_addr[0] !== 30'h200 ||
        log_addr[1] !== 30'h201 || log_addr[2] !== 30'h200 || log_addr[3] !== 30'h201)
      $display("FAIL clamp_bl0: got beats=%0d a0=%h a1=%h, required 4 beats 200,201,200,201",
               log_addr.size(), log_addr[0], log_addr[1]);
    else n_pass++;
    // cfg_bl=40 clamps to 16; three bursts at 0, 16, 32.
    run(30'h0, 8'd40, 8'd3, got);
    nwr = 0; bad = 0; v = 32'h1;
    foreach (log_we[i]) if (log_we[i]) begin
      if (log_addr[i] !== AW'(nwr) || log_dat[i] !== v) bad++;
      v = tb_next(v);
      nwr++;
    end
    n_checks++;
    if (got !== 1'b1 || nwr !== 48) $display("FAIL clamp_bl40_writes: got %0d, required 48", nwr);
    else n_pass++;
    n_checks++;
    if (log_addr[0] !== 30'd0 || log_addr[16] !== 30'd16 || log_addr[32] !== 30'd32)
      $display("FAIL clamp_bases: got %h %h %h, required 0 10 20",
               log_addr[0], log_addr[16], log_addr[32]);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL clamp_write_seq: got %0d bad beats, required 0", bad);
    else n_pass++;
    gmin = 1000; gmax = 0;
    foreach (gap_runs[i]) begin
      if (gap_runs[i] < gmin) gmin = gap_runs[i];
      if (gap_runs[i] > gmax) gmax = gap_runs[i];
    end
    n_checks++;
    if (gap_runs.size() !== 6 || gmin !== 1 || gmax !== 1)
      $display("FAIL clamp_gaps: got count=%0d min=%0d max=%0d, required 6/1/1",
               gap_runs.size(), gmin, gmax);
    else n_pass++;
    n_checks++;
    if (pass !== 1'b1 || err_cnt !== 16'd0)
      $display("FAIL clamp_pass: got pass=%b err=%0d, required 1/0", pass, err_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit got;
    logic [AW-1:0] exp_a [4];
    exp_a = '{30'h3FFF_FFFE, 30'h3FFF_FFFF, 30'h0, 30'h1};
    run(30'h3FFF_FFFE, 8'd4, 8'd1, got);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (log_addr[i] !== exp_a[i] || log_addr[4+i] !== exp_a[i])
        $display("FAIL wrap_addr%0d: got wr=%h rd=%h, required %h", i, log_addr[i],
                 log_addr[4+i], exp_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (got !== 1'b1 || pass !== 1'b1)
      $display("FAIL wrap_pass: got done=%b pass=%b, required 1/1", got, pass);
    else n_pass++;
  endtask

  task automatic test_init_gating();
    bit stb_seen, got, busy_low;
    int nwr;
    sdr_init_done = 1'b0;
    clear_logs();
    pulse_start(30'h40, 8'd2, 8'd1);
    stb_seen = 1'b0; busy_low = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (wb_stb_o || wb_cyc_o) stb_seen = 1'b1;
      if (!busy) busy_low = 1'b1;
      if (i == 100) begin
        cfg_start_addr = 30'h80; cfg_bl = 8'd8; cfg_num_bursts = 8'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (stb_seen !== 1'b0 || busy_low !== 1'b0)
      $display("FAIL init_hold: got stb_seen=%b busy_low=%b, required 0/0", stb_seen, busy_low);
    else n_pass++;
    @(posedge sys_clk);
    #1 sdr_init_done = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (wb_stb_o !== 1'b0) $display("FAIL init_latency0: got stb=%b, required 0", wb_stb_o);
    else n_pass++;
    @(negedge sys_clk);
    n_checks++;
    if (wb_stb_o !== 1'b1 || wb_addr_o !== 30'h40)
      $display("FAIL init_latency1: got stb=%b addr=%h, required 1/40", wb_stb_o, wb_addr_o);
    else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge sys_clk);
      if (done) got = 1'b1;
    end
    @(negedge sys_clk);
    nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++;
    n_checks++;
    if (got !== 1'b1 || nwr !== 2 || pass !== 1'b1)
      $display("FAIL init_busy_start_ignored: got done=%b writes=%0d pass=%b, required 1/2/1",
               got, nwr, pass);
    else n_pass++;
  endtask

  task automatic test_stall_reset();
    bit got;
    int nwr;
    stall_ack = 1'b1;
    clear_logs();
    pulse_start(30'h100, 8'd4, 8'd1);
    repeat (2000) @(negedge sys_clk);
`ifdef WBGEN_TIMEOUT_EN
    n_checks++;
    if (timeout !== 1'b1 || pass !== 1'b0 || wb_cyc_o !== 1'b0 || done !== 1'b1)
      $display("FAIL stall_timeout: got tmo=%b pass=%b cyc=%b done=%b, required 1/0/0/1",
               timeout, pass, wb_cyc_o, done);
    else n_pass++;
    pulse_start(30'h100, 8'd4, 8'd1);
    repeat (10) @(negedge sys_clk);
`else
    n_checks++;
    if (timeout !== 1'b0 || wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || busy !== 1'b1)
      $display("FAIL stall_wait: got tmo=%b cyc=%b stb=%b busy=%b, required 0/1/1/1",
               timeout, wb_cyc_o, wb_stb_o, busy);
    else n_pass++;
`endif
    n_checks++;
    if (wb_cyc_o !== 1'b1) $display("FAIL stall_midrun: got cyc=%b, required 1", wb_cyc_o);
    else n_pass++;
    #2 RESETN = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) $display("FAIL async_reset: got %h, required 0", all_outs());
    else n_pass++;
    stall_ack = 1'b0;
    @(negedge sys_clk);
    RESETN = 1'b1;
    @(negedge sys_clk);
    run(30'h300, 8'd4, 8'd1, got);
    nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++;
    n_checks++;
    if (got !== 1'b1 || pass !== 1'b1 || nwr !== 4 || log_dat[0] !== 32'h1 ||
        log_addr[0] !== 30'h300)
      $display("FAIL post_reset_run: got done=%b pass=%b writes=%0d d0=%h a0=%h, required 1/1/4/1/300",
               got, pass, nwr, log_dat[0], log_addr[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_corrupt();
    test_clamp_gap();
    test_wrap();
    test_init_gating();
    test_stall_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_traffic_gen.md
Name: wb_traffic_gen

Overview:
- Synthesizable Wishbone master that sits directly upstream of the SDRAM controller's Wishbone slave port; it replaces the testbench burst_write/burst_read tasks for on-chip and FPGA bring-up.
- Writes N bursts of pseudo-random data, then reads them back in the same order and checks every beat.
- Reports pass/fail, an error count and the first failing address.

Parameters:
- AW, 30, Wishbone word-address width (byte address bits [31:2]).
- DW, 32, data width; sel width is DW/8.
- MAX_BL, 16, maximum beats per burst.
- SEED, 32'hACE1_2024, LFSR seed; a seed of 0 is replaced by 1.
- TIMEOUT, 1024, cycles allowed per beat before abort. Used only with WBGEN_TIMEOUT_EN.

Ports:
- sys_clk, in, 1, sole clock.
- RESETN, in, 1, asynchronous active-low reset.
- sdr_init_done, in, 1, SDRAM initialisation complete.
- start, in, 1, single-cycle pulse that launches a run.
- cfg_start_addr, in, AW, word address of the first burst.
- cfg_bl, in, 8, beats per burst.
- cfg_num_bursts, in, 8, number of bursts.
- busy, out, 1, run in progress.
- done, out, 1, run finished (sticky until the next start).
- pass, out, 1, done and err_cnt==0 and no timeout.
- err_cnt, out, 16, saturating count of mismatched read beats.
- first_err_addr, out, AW, word address of the first mismatch.
- timeout, out, 1, run aborted on a stalled ack (tied 0 without WBGEN_TIMEOUT_EN).
- wb_cyc_o / wb_stb_o / wb_we_o, out, 1 each, Wishbone control.
- wb_addr_o, out, AW, Wishbone word address.
- wb_sel_o, out, DW/8, byte selects.
- wb_dat_o, out, DW, write data.
- wb_dat_i, in, DW, read data.
- wb_ack_i, in, 1, slave acknowledge.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and the LFSR holds SEED. Reset mid-run drops cyc/stb asynchronously; no partial state survives.
- All outputs are registered.
- FSM states: IDLE, WAIT_INIT, WR_BEAT, WR_GAP, RD_BEAT, RD_GAP, DONE.
- Transitions:
  - IDLE / DONE: on start, latch cfg_*, clear err_cnt / first_err_addr / done / timeout / pass, reload LFSR=SEED, go to WAIT_INIT.
  - start while busy is ignored.
  - WAIT_INIT: wait for sdr_init_done==1. If cfg_num_bursts==0, go to DONE with pass=1 and issue no bus cycles; otherwise go to WR_BEAT.
  - WR_BEAT: cyc=stb=we=1, sel=all ones, addr=burst_base+beat, dat=LFSR. On a posedge with ack=1, the LFSR advances and beat increments.
    - Next beat: cyc/stb stay high and the new addr/dat are visible in the following cycle.
    - After the last beat of a burst: go to WR_GAP.
  - WR_GAP: exactly one cycle with cyc=stb=0.
    - Then next burst: burst_base += bl.
    - After the last burst: reload LFSR=SEED, reset burst_base=cfg_start_addr, go to RD_BEAT.
  - RD_BEAT / RD_GAP: same sequencing with we=0, sel=all ones, and wb_dat_o holding its last value. On ack, compare wb_dat_i to the LFSR value, then advance.
  - After the final RD_GAP: go to DONE, with busy=0, done=1, pass=(err_cnt==0 && !timeout).
- Effective burst length: cfg_bl==0 is treated as 1; cfg_bl>MAX_BL is clamped to MAX_BL.
- Address arithmetic is modulo 2^AW and wraps silently. Bursts are contiguous: burst k starts at cfg_start_addr + k*bl_eff.
- Mismatch on an acked read beat: err_cnt increments (saturating at 16'hFFFF). first_err_addr is captured only on the first mismatch.
- ack while stb=0 is ignored. ack is sampled only on posedge while stb=1.
- LFSR: 32-bit Galois, polynomial 0x80200003, shifts once per acked write or read beat. For DW>32 the word is replicated.
- Latency: the first stb rises 1 cycle after WAIT_INIT sees sdr_init_done. Minimum cycles per burst = bl_eff + 1.

Optional Feature:
- Macro: WBGEN_TIMEOUT_EN.
- Defined:
  - A per-beat counter resets on every ack and on every beat entry.
  - If it reaches TIMEOUT with no ack: drop cyc/stb next cycle, set timeout=1, go to DONE with pass=0.
- Undefined: no counter is built, timeout is tied 0, and the FSM waits indefinitely for ack.

Decomposition:
- Package wbgen_pkg:
  - state enum wbgen_state_e;
  - LFSR_POLY constant 32'h80200003;
  - default SEED constant;
  - function bl_eff(cfg_bl, MAX_BL).
- Sub-module wbgen_lfsr: ports sys_clk, RESETN, load, seed, advance, value.

Test Plan:
- Single burst: SEED=1, cfg_start_addr=30'h1_0000, cfg_bl=4, cfg_num_bursts=1, ideal slave with ack the cycle after stb → 4 writes to 1_0000..1_0003, a 1-cycle gap, 4 reads; done=1, pass=1, err_cnt=0.
- Corrupt read: slave flips bit0 on the read of word 1_0002 → err_cnt=1, first_err_addr=30'h1_0002, pass=0.
- Clamp and gap: cfg_bl=0 gives 1 beat per burst; cfg_bl=40 gives 16 beats. cfg_num_bursts=3 gives bases 0, 16, 32 and cyc low for exactly one cycle between bursts.
- Wrap: cfg_start_addr=30'h3FFF_FFFE, cfg_bl=4 → addresses 3FFF_FFFE, 3FFF_FFFF, 0, 1; pass=1.
- Stall and reset: slave withholds ack for 2000 cycles.
  - With WBGEN_TIMEOUT_EN and TIMEOUT=1024: timeout=1, pass=0, cyc=0.
  - Then RESETN low mid-run: all outputs 0 immediately, and a start after release runs cleanly.
- Init gating: start with sdr_init_done=0 for 500 cycles → no stb until sdr_init_done rises; start pulses while busy are ignored.
